imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage of the RISC-V pipeline CPU.
- Classifies the instruction format from the opcode and emits one selected sign- or zero-extended immediate with its format code.
- Also emits the PC-relative target PC+IMM and an illegal-opcode flag.
- Two register stages with valid/ready flow control and a synchronous flush, so it sits between fetch/IF-ID and the register-read stage.

---
 rtl/imm_gen_pkg.sv | 32 +++
 rtl/imm_extract.sv | 99 +++++++++
 rtl/imm_gen_pipe.sv | 102 ++++++++++
 tb/tb_imm_gen_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcode, immediate-format and funct3 encodings for the RISC-V
// immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_NONE  = 3'd7
    } imm_fmt_e;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decode: classifies the instruction format from the
// opcode and produces the extended immediate plus an illegal-opcode flag.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal
);

    localparam int SHAMT_W = $clog2(XLEN);
    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0]      w_opc;
    logic            w_is_shift;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_sh;
    logic [XLEN-1:0] w_imm_sh5;

    assign w_opc      = i_instr[6:0];
    assign w_is_shift = (i_instr[14:12] == F3_SLL) || (i_instr[14:12] == F3_SRL_SRA);

    assign w_imm_i   = XLEN'($signed(i_instr[31:20]));
    assign w_imm_s   = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_b   = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                      i_instr[11:8], 1'b0}));
    assign w_imm_u   = XLEN'($signed({i_instr[31:12], 12'b0}));
    assign w_imm_j   = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                      i_instr[30:21], 1'b0}));
    assign w_imm_sh  = XLEN'(i_instr[20 +: SHAMT_W]);
    // Word shifts on RV64 only ever take a 5-bit amount.
    assign w_imm_sh5 = XLEN'(i_instr[24:20]);

    always_comb begin
        o_imm     = '0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                o_fmt = FMT_I;
                o_imm = w_imm_i;
            end
            OPC_OP_IMM: begin
                if (w_is_shift) begin
                    o_fmt = FMT_SHAMT;
                    o_imm = w_imm_sh;
                end else begin
                    o_fmt = FMT_I;
                    o_imm = w_imm_i;
                end
            end
            OPC_OP_IMM_32: begin
                if (!IS_RV64) begin
                    o_illegal = 1'b1;
                end else if (w_is_shift) begin
                    o_fmt = FMT_SHAMT;
                    o_imm = w_imm_sh5;
                end else begin
                    o_fmt = FMT_I;
                    o_imm = w_imm_i;
                end
            end
            OPC_STORE: begin
                o_fmt = FMT_S;
                o_imm = w_imm_s;
            end
            OPC_BRANCH: begin
                o_fmt = FMT_B;
                o_imm = w_imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_fmt = FMT_U;
                o_imm = w_imm_u;
            end
            OPC_JAL: begin
                o_fmt = FMT_J;
                o_imm = w_imm_j;
            end
            OPC_OP: begin
                o_fmt = FMT_R;
            end
            OPC_OP_32: begin
                if (IS_RV64) o_fmt = FMT_R;
                else         o_illegal = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator with valid/ready flow control and flush.
// S1 holds the decoded immediate, S2 adds the PC-relative target.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INSTRUCTION,
    input  logic [XLEN-1:0] PC,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] IMM,
    output logic [2:0]      IMM_FMT,
    output logic [XLEN-1:0] TARGET,
    output logic            ILLEGAL,
    output logic [XLEN-1:0] PC_OUT
);

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic            w_s1_load;
    logic            w_s2_load;

    logic            r_v1;
    logic [XLEN-1:0] r_imm1;
    logic [2:0]      r_fmt1;
    logic            r_ill1;
    logic [XLEN-1:0] r_pc1;

    logic            r_v2;
    logic [XLEN-1:0] r_imm2;
    logic [2:0]      r_fmt2;
    logic            r_ill2;
    logic [XLEN-1:0] r_pc2;
    logic [XLEN-1:0] r_tgt2;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_instr   (INSTRUCTION),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_ill)
    );

    assign w_s2_load = !r_v2 || OUT_READY;
    assign w_s1_load = !r_v1 || w_s2_load;
    assign IN_READY  = w_s1_load;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v1   <= 1'b0;
            r_imm1 <= '0;
            r_fmt1 <= FMT_NONE;
            r_ill1 <= 1'b0;
            r_pc1  <= '0;
        end else begin
            if (FLUSH)          r_v1 <= 1'b0;
            else if (w_s1_load) r_v1 <= IN_VALID;
            if (w_s1_load && IN_VALID) begin
                r_imm1 <= w_imm;
                r_fmt1 <= w_fmt;
                r_ill1 <= w_ill;
                r_pc1  <= PC;
            end
        end
    end

    // Data registers may pick up a flushed entry; only the valids matter then.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v2   <= 1'b0;
            r_imm2 <= '0;
            r_fmt2 <= FMT_NONE;
            r_ill2 <= 1'b0;
            r_pc2  <= '0;
            r_tgt2 <= '0;
        end else begin
            if (FLUSH)          r_v2 <= 1'b0;
            else if (w_s2_load) r_v2 <= r_v1;
            if (w_s2_load && r_v1) begin
                r_imm2 <= r_imm1;
                r_fmt2 <= r_fmt1;
                r_ill2 <= r_ill1;
                r_pc2  <= r_pc1;
                r_tgt2 <= r_pc1 + r_imm1;
            end
        end
    end

    assign OUT_VALID = r_v2;
    assign IMM       = r_imm2;
    assign IMM_FMT   = r_fmt2;
    assign ILLEGAL   = r_ill2;
    assign PC_OUT    = r_pc2;
    assign TARGET    = r_tgt2;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 instance under random traffic with a
// scoreboard and directed cases, plus an XLEN=64 instance for RV64 decode.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [63:0] pc;
        int          fmt;
        bit          ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] instr, pc, imm, target, pc_out;
    logic [2:0]  imm_fmt;

    logic        flush_64, in_valid_64, in_ready_64, out_valid_64, out_ready_64, illegal_64;
    logic [31:0] instr_64;
    logic [63:0] pc_64, imm_64, target_64, pc_out_64;
    logic [2:0]  imm_fmt_64;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];

    imm_gen_pipe #(.XLEN(32)) dut (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .INSTRUCTION(instr), .PC(pc),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .IMM(imm), .IMM_FMT(imm_fmt), .TARGET(target),
        .ILLEGAL(illegal), .PC_OUT(pc_out)
    );

    imm_gen_pipe #(.XLEN(64)) dut_64 (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush_64),
        .IN_VALID(in_valid_64), .IN_READY(in_ready_64),
        .INSTRUCTION(instr_64), .PC(pc_64),
        .OUT_VALID(out_valid_64), .OUT_READY(out_ready_64),
        .IMM(imm_64), .IMM_FMT(imm_fmt_64), .TARGET(target_64),
        .ILLEGAL(illegal_64), .PC_OUT(pc_out_64)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic longint sx(input longint v, input int bits);
        longint half = longint'(1) << (bits - 1);
        return (v >= half) ? v - 2 * half : v;
    endfunction

    // Reference decode: immediates built as signed integers from field weights.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] pc_in, input int xlen);
        exp_t        e;
        longint      v;
        logic [63:0] m;
        int          op;
        int          f3;
        bit          shift;
        op    = int'(ins[6:0]);
        f3    = int'(ins[14:12]);
        shift = (f3 == 1) || (f3 == 5);
        v     = 0;
        e.fmt = 7;
        e.ill = 1'b0;
        case (op)
            'h03, 'h67, 'h73: begin e.fmt = 1; v = sx(longint'(ins[31:20]), 12); end
            'h13: begin
                if (shift) begin e.fmt = 6; v = longint'(ins[25:20]) % xlen; end
                else       begin e.fmt = 1; v = sx(longint'(ins[31:20]), 12); end
            end
            'h1B: begin
                if (xlen != 64) e.ill = 1'b1;
                else if (shift) begin e.fmt = 6; v = longint'(ins[24:20]); end
                else begin e.fmt = 1; v = sx(longint'(ins[31:20]), 12); end
            end
            'h23: begin e.fmt = 2; v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); end
            'h63: begin
                e.fmt = 3;
                v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                       longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            end
            'h37, 'h17: begin e.fmt = 4; v = sx(longint'(ins[31:12]) * 4096, 32); end
            'h6F: begin
                e.fmt = 5;
                v = sx(longint'(ins[31]) * (longint'(1) << 20) + longint'(ins[19:12]) * 4096 +
                       longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            end
            'h33: e.fmt = 0;
            'h3B: begin if (xlen == 64) e.fmt = 0; else e.ill = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        m     = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.imm = 64'(v) & m;
        e.pc  = pc_in & m;
        e.tgt = (pc_in + 64'(v)) & m;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [13];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37,
                7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
        else                           r[6:0] = ops[$urandom_range(0, 12)];
        return r;
    endfunction

    // Scoreboard for the 32-bit instance; outputs sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (sb.size() == 0) begin
                check_eq("no_spurious_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                check_eq("sb_imm",    64'(imm),     sb[0].imm);
                check_eq("sb_fmt",    64'(imm_fmt), 64'(sb[0].fmt));
                check_eq("sb_illegal",64'(illegal), 64'(sb[0].ill));
                check_eq("sb_target", 64'(target),  sb[0].tgt);
                check_eq("sb_pc_out", 64'(pc_out),  sb[0].pc);
                if (out_ready) void'(sb.pop_front());
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(ref_model(instr, 64'(pc), 32));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hs(input logic [31:0] ins, input logic [31:0] pcv);
        int budget = 20;
        instr = ins; pc = pcv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            tick();
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_eq("push_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_one32(input logic [31:0] ins, input logic [31:0] pcv,
                              input logic [31:0] k_imm, input int k_fmt,
                              input logic [31:0] k_tgt, input bit k_ill);
        instr = ins; pc = pcv; in_valid = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_c1_not_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check_eq("lat_c2_valid", 64'(out_valid), 64'd1);
        check_eq("k_imm",     64'(imm),     64'(k_imm));
        check_eq("k_fmt",     64'(imm_fmt), 64'(k_fmt));
        check_eq("k_target",  64'(target),  64'(k_tgt));
        check_eq("k_illegal", 64'(illegal), 64'(k_ill));
        tick();
    endtask

    task automatic send64(input logic [31:0] ins, input logic [63:0] pcv,
                          input bit use_k, input logic [63:0] k_imm, input int k_fmt);
        exp_t e = ref_model(ins, pcv, 64);
        instr_64 = ins; pc_64 = pcv; in_valid_64 = 1'b1;
        tick();
        in_valid_64 = 1'b0;
        tick();
        @(negedge clk);
        check_eq("x64_valid",   64'(out_valid_64), 64'd1);
        check_eq("x64_imm",     imm_64,            e.imm);
        check_eq("x64_fmt",     64'(imm_fmt_64),   64'(e.fmt));
        check_eq("x64_illegal", 64'(illegal_64),   64'(e.ill));
        check_eq("x64_target",  target_64,         e.tgt);
        check_eq("x64_pc_out",  pc_out_64,         e.pc);
        if (use_k) begin
            check_eq("x64_k_imm", imm_64,          k_imm);
            check_eq("x64_k_fmt", 64'(imm_fmt_64), 64'(k_fmt));
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; pc = '0;
        flush_64 = 1'b0; in_valid_64 = 1'b0; out_ready_64 = 1'b1; instr_64 = '0; pc_64 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_imm_fmt",   64'(imm_fmt),   64'd7);
        check_eq("rst_imm",       64'(imm),       64'd0);
        check_eq("rst_target",    64'(target),    64'd0);
        check_eq("rst_pc_out",    64'(pc_out),    64'd0);
        check_eq("rst_illegal",   64'(illegal),   64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        send_one32(32'hFFF00093, 32'h100, 32'hFFFF_FFFF, 1, 32'h0000_00FF, 1'b0);
        send_one32(32'h4030D093, 32'h100, 32'h0000_0003, 6, 32'h0000_0103, 1'b0);
        send_one32(32'h123452B7, 32'h100, 32'h1234_5000, 4, 32'h1234_5100, 1'b0);
        send_one32(32'hFE000EE3, 32'h100, 32'hFFFF_FFFC, 3, 32'h0000_00FC, 1'b0);
        send_one32(32'h0080006F, 32'h100, 32'h0000_0008, 5, 32'h0000_0108, 1'b0);
        send_one32(32'h0000007F, 32'h100, 32'h0000_0000, 7, 32'h0000_0100, 1'b1);
        send_one32(32'h0000101B, 32'h200, 32'h0000_0000, 7, 32'h0000_0200, 1'b1);

        // Back-pressure: two entries fill the pipe, then the input stalls.
        out_ready = 1'b0;
        push_hs(32'h00500113, 32'h1000);
        push_hs(32'h00A00193, 32'h1004);
        instr = 32'h00F00213; pc = 32'h1008; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready_low", 64'(in_ready),  64'd0);
            check_eq("bp_out_held",     64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        push_hs(32'h00F00213, 32'h1008);
        push_hs(32'h01400293, 32'h100C);
        repeat (4) tick();
        @(negedge clk);
        check_eq("bp_drained", 64'(sb.size()), 64'd0);
        tick();

        // Flush with both stages full and an instruction offered.
        out_ready = 1'b0;
        push_hs(32'h06400313, 32'h2000);
        push_hs(32'h0C800393, 32'h2004);
        instr = 32'h12C00413; pc = 32'h2008; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (4) tick();

        // Flush on the cycle an input is accepted into an empty pipe.
        instr = 32'h00100493; pc = 32'h3000; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check_eq("flush_accept_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        @(negedge clk);
        check_eq("flush_drops_input", 64'(out_valid), 64'd0);
        tick();

        // Asynchronous reset between clock edges with data in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = rand_instr(); pc = $urandom;
            tick();
        end
        check_eq("pre_reset_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_imm_fmt",   64'(imm_fmt),   64'd7);
        check_eq("arst_imm",       64'(imm),       64'd0);
        check_eq("arst_target",    64'(target),    64'd0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        send_one32(32'h0080006F, 32'h400, 32'h0000_0008, 5, 32'h0000_0408, 1'b0);

        // Random traffic with random stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 29) == 0);
            instr     = rand_instr();
            pc        = $urandom;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check_eq("rand_drained", 64'(sb.size()), 64'd0);

        // RV64 instance.
        send64(32'h03F09093, 64'h100, 1'b1, 64'd63, 6);
        send64(32'h0010809B, 64'h100, 1'b1, 64'd1, 1);
        send64(32'hFE000EE3, 64'h100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 3);
        send64(32'h0000503B, 64'h100, 1'b1, 64'd0, 0);
        send64(32'h800002B7, 64'h100, 1'b1, 64'hFFFF_FFFF_8000_0000, 4);
        for (int i = 0; i < 40; i++) begin
            send64(rand_instr(), {32'($urandom), 32'($urandom)}, 1'b0, 64'd0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
